// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-bus req/ack interface between the MEM stage and memory
interface mem_bus_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with big-endian lane handling
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        addr_err_o,
    output logic        bus_err_o,
    mem_bus_if.master   bus
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] cnt;
    logic [31:0] rdata_q;
    logic        abort_q, err_q, load_q, sgn_q;
    logic [1:0]  size_q, off_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;

    logic        is_load, is_store, sgn, aligned, mem_op, timeout_hit;
    logic [1:0]  size;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, ext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        unused_stall;

    assign unused_stall = ^{stall_i[5], stall_i[3:0]};
    assign mem_op       = is_load | is_store;
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);

    // Decode the memory opcode into direction, access size and signedness
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_W;
        sgn      = 1'b0;
        case (aluop_i)
            OP_LB:  begin is_load = 1'b1;  size = SZ_B; sgn = 1'b1; end
            OP_LBU: begin is_load = 1'b1;  size = SZ_B; end
            OP_LH:  begin is_load = 1'b1;  size = SZ_H; sgn = 1'b1; end
            OP_LHU: begin is_load = 1'b1;  size = SZ_H; end
            OP_LW:  begin is_load = 1'b1;  size = SZ_W; end
            OP_SB:  begin is_store = 1'b1; size = SZ_B; end
            OP_SH:  begin is_store = 1'b1; size = SZ_H; end
            OP_SW:  begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

    // Alignment check plus big-endian lane enables and replicated store data
    always_comb begin
        aligned = 1'b1;
        sel_c   = 4'b1111;
        wdata_c = reg2_i;
        case (size)
            SZ_B: begin
                sel_c   = 4'b1000 >> mem_addr_i[1:0];
                wdata_c = {4{reg2_i[7:0]}};
            end
            SZ_H: begin
                aligned = ~mem_addr_i[0];
                sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{reg2_i[15:0]}};
            end
            default: aligned = (mem_addr_i[1:0] == 2'b00);
        endcase
    end

    // Pick the addressed lane out of the captured word and extend it
    always_comb begin
        byte_v = rdata_q[{~off_q, 3'b000} +: 8];
        half_v = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size_q)
            SZ_B:    ext = sgn_q ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            SZ_H:    ext = sgn_q ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            default: ext = rdata_q;
        endcase
    end

    // Transaction FSM: issue one bus cycle, wait for ack or timeout, then report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_W;
            off_q   <= 2'b00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_op && aligned) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {mem_addr_i[31:2], 2'b00};
                        sel_q   <= sel_c;
                        wdata_q <= wdata_c;
                        cnt     <= '0;
                        abort_q <= 1'b0;
                        load_q  <= is_load;
                        sgn_q   <= sgn;
                        size_q  <= size;
                        off_q   <= mem_addr_i[1:0];
                        state   <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus.bus_ack_i) begin
                        rdata_q <= bus.bus_rdata_i;
                        req_q   <= 1'b0;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        abort_q <= 1'b1;
                        err_q   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    if (!stall_i[4]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-back triple, stall request and misalignment pulse
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stallreq_o = 1'b0;
        addr_err_o = 1'b0;
        if (rst) begin
            wd_o    = '0;
            wreg_o  = 1'b0;
            wdata_o = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        wreg_o  = 1'b0;
                        wdata_o = '0;
                        if (aligned) stallreq_o = 1'b1;
                        else         addr_err_o = 1'b1;
                    end
                end
                S_BUS: begin
                    wreg_o     = 1'b0;
                    wdata_o    = '0;
                    stallreq_o = 1'b1;
                end
                default: begin
                    wreg_o  = (load_q && !abort_q) ? wreg_i : 1'b0;
                    wdata_o = load_q ? ext : '0;
                end
            endcase
        end
    end

    assign bus_err_o       = err_q & ~rst;
    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_wdata_o = wdata_q;
endmodule
